// File: rtl/seq_pkg.sv
// seq_pkg: shared types and constants for the instruction sequencer.
//   seq_state_t : sequencer FSM state encoding
//   HALT_OPC    : opcode field value that stops the program
//   INSTR_W     : instruction word width
//   is_halt()   : true when an instruction word carries the HALT opcode
package seq_pkg;

    localparam int INSTR_W = 16;
    localparam logic [2:0] HALT_OPC = 3'b111;

    typedef enum logic [3:0] {
        IDLE,
        FETCH,
        MEMWAIT,
        LOAD,
        START,
        EXEC_LO,
        EXEC_HI,
        HALT,
        ERROR
    } seq_state_t;

    function automatic logic is_halt(input logic [INSTR_W-1:0] word);
        return word[INSTR_W-1 -: 3] == HALT_OPC;
    endfunction

endpackage

// File: rtl/seq_watchdog.sv
// seq_watchdog: per-instruction execution timeout.
//   clk     : rising-edge clock
//   reset   : synchronous, active-high
//   clr     : return the count to zero
//   en      : count this cycle (sequencer is waiting on the cpu)
//   expired : count reaches WDT_CYCLES-1 on this edge; the sequencer
//             aborts unless its exit condition is met in the same cycle
// WDT_CYCLES must be at least 2.
module seq_watchdog
    import seq_pkg::*;
#(
    parameter int WDT_CYCLES = 64
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    localparam int CW = $clog2(WDT_CYCLES) + 1;
    localparam logic [CW-1:0] CNT_MAX  = CW'(WDT_CYCLES - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(WDT_CYCLES - 2);

    logic [CW-1:0] cnt;

    // Saturates at WDT_CYCLES-1 so a stuck enable never wraps back to zero.
    always_ff @(posedge clk) begin
        if (reset || clr) begin
            cnt <= '0;
        end else if (en && (cnt != CNT_MAX)) begin
            cnt <= cnt + CW'(1);
        end
    end

    assign expired = en && (cnt >= CNT_LAST);

endmodule

// File: rtl/instr_sequencer.sv
// instr_sequencer: autonomous program runner feeding the cpu.
// Fetches 16-bit words from a sync-read ROM, hands each to the cpu through
// the load/s handshake, waits for the cpu to return to its wait state and
// advances the PC. Stops on a HALT opcode or a watchdog timeout.
//   clk, reset          : clock, synchronous active-high reset
//   run                 : start request, honoured only in IDLE/HALT/ERROR
//   mem_addr, mem_rd    : ROM address (= PC) and read strobe
//   mem_rdata           : ROM data, valid the cycle after mem_rd
//   cpu_in              : instruction register to the cpu
//   cpu_load, cpu_s     : single-cycle load and start pulses to the cpu
//   cpu_w               : cpu wait flag (1 = cpu idle)
//   busy, halted, err   : status
//
// state   | meaning
// --------+----------------------------------------------------------
// IDLE    | after reset, waiting for run
// FETCH   | ROM read strobe issued for address PC
// MEMWAIT | ROM data arriving, captured into IR, HALT opcode checked
// LOAD    | offering IR to the cpu; load pulses once cpu_w=1
// START   | start pulse to the cpu, watchdog cleared
// EXEC_LO | waiting for the cpu to leave its wait state
// EXEC_HI | waiting for the cpu to finish, then PC+1
// HALT    | HALT word seen, PC parked on it; run restarts
// ERROR   | watchdog expired, PC parked; run restarts
module instr_sequencer
    import seq_pkg::*;
#(
    parameter int                ADDR_W     = 8,
    parameter logic [ADDR_W-1:0] START_ADDR = '0,
    parameter int                WDT_CYCLES = 64
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               run,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_rd,
    input  logic [INSTR_W-1:0] mem_rdata,
    output logic [INSTR_W-1:0] cpu_in,
    output logic               cpu_load,
    output logic               cpu_s,
    input  logic               cpu_w,
    output logic               busy,
    output logic               halted,
    output logic               err
);

    seq_state_t state, state_nxt;

    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] ir;

    logic pc_restart;
    logic pc_inc;
    logic ir_ld;
    logic wdt_clr;
    logic wdt_en;
    logic wdt_expired;

    assign wdt_en = (state == EXEC_LO) || (state == EXEC_HI);

    seq_watchdog #(
        .WDT_CYCLES(WDT_CYCLES)
    ) u_wdt (
        .clk    (clk),
        .reset  (reset),
        .clr    (wdt_clr),
        .en     (wdt_en),
        .expired(wdt_expired)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt  = state;
        pc_restart = 1'b0;
        pc_inc     = 1'b0;
        ir_ld      = 1'b0;
        wdt_clr    = 1'b0;
        case (state)
            IDLE, HALT, ERROR: begin
                if (run) begin
                    state_nxt  = FETCH;
                    pc_restart = 1'b1;
                    wdt_clr    = 1'b1;
                end
            end
            FETCH:   state_nxt = MEMWAIT;
            MEMWAIT: begin
                ir_ld     = 1'b1;
                state_nxt = is_halt(mem_rdata) ? HALT : LOAD;
            end
            LOAD: begin
                if (cpu_w) begin
                    state_nxt = START;
                end
            end
            START: begin
                wdt_clr   = 1'b1;
                state_nxt = EXEC_LO;
            end
            // The exit condition is tested before expiry so an instruction
            // finishing on the last allowed cycle still completes.
            EXEC_LO: begin
                if (!cpu_w) begin
                    state_nxt = EXEC_HI;
                end else if (wdt_expired) begin
                    state_nxt = ERROR;
                end
            end
            EXEC_HI: begin
                if (cpu_w) begin
                    pc_inc    = 1'b1;
                    state_nxt = FETCH;
                end else if (wdt_expired) begin
                    state_nxt = ERROR;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_rd   = (state == FETCH);
        cpu_load = (state == LOAD) && cpu_w;
        cpu_s    = (state == START);
        busy     = !((state == IDLE) || (state == HALT) || (state == ERROR));
        halted   = (state == HALT);
        err      = (state == ERROR);
    end

    // PC wraps naturally at 2**ADDR_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            pc <= START_ADDR;
            ir <= '0;
        end else begin
            if (pc_restart) begin
                pc <= START_ADDR;
            end else if (pc_inc) begin
                pc <= pc + ADDR_W'(1);
            end
            if (ir_ld) begin
                ir <= mem_rdata;
            end
        end
    end

    assign mem_addr = pc;
    assign cpu_in   = ir;

endmodule

// File: tb/tb_instr_sequencer.sv
module tb_instr_sequencer;
    import seq_pkg::*;

    localparam int WDT = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset = 1'b1;
    logic        run = 1'b0;
    logic        run2 = 1'b0;

    logic [7:0]  mem_addr;
    logic        mem_rd;
    logic [15:0] mem_rdata;
    logic [15:0] cpu_in;
    logic        cpu_load, cpu_s, cpu_w;
    logic        busy, halted, err;

    logic [1:0]  mem_addr2;
    logic        mem_rd2;
    logic [15:0] mem_rdata2;
    logic [15:0] cpu_in2;
    logic        cpu_load2, cpu_s2, cpu_w2;
    logic        busy2, halted2, err2;

    instr_sequencer #(.ADDR_W(8), .START_ADDR(8'd0), .WDT_CYCLES(WDT)) dut (
        .clk(clk), .reset(reset), .run(run),
        .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_rdata(mem_rdata),
        .cpu_in(cpu_in), .cpu_load(cpu_load), .cpu_s(cpu_s), .cpu_w(cpu_w),
        .busy(busy), .halted(halted), .err(err)
    );

    instr_sequencer #(.ADDR_W(2), .START_ADDR(2'd0), .WDT_CYCLES(WDT)) dut2 (
        .clk(clk), .reset(reset), .run(run2),
        .mem_addr(mem_addr2), .mem_rd(mem_rd2), .mem_rdata(mem_rdata2),
        .cpu_in(cpu_in2), .cpu_load(cpu_load2), .cpu_s(cpu_s2), .cpu_w(cpu_w2),
        .busy(busy2), .halted(halted2), .err(err2)
    );

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ROM models: one-cycle read latency.
    logic [15:0] rom [256];
    logic [15:0] rom2 [4];
    always @(posedge clk) if (mem_rd) mem_rdata <= rom[mem_addr];
    always @(posedge clk) if (mem_rd2) mem_rdata2 <= rom2[mem_addr2];

    // Behavioural cpu: latches in on load, drops w for lat cycles after s,
    // executes when w returns.
    logic [15:0] regs [8];
    logic [15:0] cir;
    int  cnt = 0;
    bit  stuck = 0;
    bit  force_low = 0;
    int  fixed_lat = 0;
    assign cpu_w = stuck ? 1'b1 : (force_low ? 1'b0 : (cnt == 0));

    function automatic logic [15:0] shv(input logic [15:0] v, input logic [1:0] sh);
        case (sh)
            2'b00:   return v;
            2'b01:   return {v[14:0], 1'b0};
            2'b10:   return {1'b0, v[15:1]};
            default: return {v[15], v[15:1]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            cnt <= 0;
            for (int i = 0; i < 8; i++) regs[i] <= '0;
        end else begin
            if (cpu_load) cir <= cpu_in;
            if (cnt != 0) begin
                if (cnt == 1) begin
                    case ({cir[15:13], cir[12:11]})
                        5'b110_10: regs[cir[10:8]] <= {{8{cir[7]}}, cir[7:0]};
                        5'b110_00: regs[cir[7:5]]  <= shv(regs[cir[2:0]], cir[4:3]);
                        5'b101_00: regs[cir[7:5]]  <= regs[cir[10:8]] + shv(regs[cir[2:0]], cir[4:3]);
                        5'b101_10: regs[cir[7:5]]  <= regs[cir[10:8]] & shv(regs[cir[2:0]], cir[4:3]);
                        default: ;
                    endcase
                end
                cnt <= cnt - 1;
            end else if (cpu_s && !stuck) begin
                cnt <= (fixed_lat != 0) ? fixed_lat : int'($urandom_range(1, 4));
            end
        end
    end

    // Second instance: cpu stub drops w for the single cycle after s.
    always @(posedge clk) begin
        if (reset) cpu_w2 <= 1'b1;
        else       cpu_w2 <= ~cpu_s2;
    end

    logic [15:0] load_q[$];
    logic [7:0]  fetch_q[$];
    logic [1:0]  fetch2_q[$];
    bit overlap = 0;
    always @(posedge clk) begin
        if (reset) begin
            load_q.delete();
            fetch_q.delete();
            fetch2_q.delete();
        end else begin
            if (cpu_load) load_q.push_back(cpu_in);
            if (mem_rd) fetch_q.push_back(mem_addr);
            if (mem_rd2) fetch2_q.push_back(mem_addr2);
        end
        if ((cpu_load && cpu_s) || (cpu_load2 && cpu_s2)) overlap <= 1'b1;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk(nm, {busy, halted, err, mem_rd, cpu_load, cpu_s, cpu_in, mem_addr}, 32'h0);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        run = 1'b0;
        run2 = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic pulse_run();
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        int n = 0;
        while (!(halted || err) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        chk({nm, " finished"}, 32'(halted || err), 32'h1);
    endtask

    // Reference: the program ends at the first word carrying the HALT opcode.
    function automatic int first_halt();
        for (int i = 0; i < 256; i++) if (rom[i][15:13] == 3'b111) return i;
        return -1;
    endfunction

    typedef struct {
        logic [7:0][15:0] prog;
        int               halt_at;
        logic [15:0]      r0, r1, r2;
    } vec_t;
    vec_t tbl[4];

    task automatic load_prog(input int v);
        for (int i = 0; i < 256; i++) rom[i] = (i < 8) ? tbl[v].prog[i[2:0]] : 16'hE000;
    endtask

    initial begin
        #500000;
        $display("FAIL global_timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int t0, n, lc0, l;
        bit any_load, busy_drop;
        string nm;

        tbl[0] = '{prog: {16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hA148, 16'hD102, 16'hD007},
                   halt_at: 3, r0: 16'h0007, r1: 16'h0002, r2: 16'h0010};
        tbl[1] = '{prog: {16'hE000, 16'hE000, 16'hE000, 16'hE5A5, 16'hA20A, 16'hA041, 16'hD105, 16'hD003},
                   halt_at: 4, r0: 16'h0018, r1: 16'h0005, r2: 16'h0008};
        tbl[2] = '{prog: {16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hD155, 16'hE000},
                   halt_at: 0, r0: 16'h0000, r1: 16'h0000, r2: 16'h0000};
        tbl[3] = '{prog: {16'hE000, 16'hE000, 16'hE000, 16'hE000, 16'hFFFF, 16'hA241, 16'hD101, 16'hD27F},
                   halt_at: 3, r0: 16'h0000, r1: 16'h0001, r2: 16'h0080};
        for (int i = 0; i < 4; i++) rom2[i] = 16'hD001;

        // Table-driven programs.
        for (int v = 0; v < 4; v++) begin
            load_prog(v);
            do_reset();
            chk_idle($sformatf("v%0d reset", v));
            pulse_run();
            wait_done($sformatf("v%0d", v));
            chk($sformatf("v%0d halted/err", v), {30'h0, halted, err}, 32'h2);
            chk($sformatf("v%0d mem_addr", v), mem_addr, tbl[v].halt_at);
            chk($sformatf("v%0d loads", v), load_q.size(), tbl[v].halt_at);
            chk($sformatf("v%0d fetches", v), fetch_q.size(), tbl[v].halt_at + 1);
            chk($sformatf("v%0d regs", v), {regs[0], regs[1]}, {tbl[v].r0, tbl[v].r1});
            chk($sformatf("v%0d r2", v), regs[2], tbl[v].r2);
        end

        // ADDR_W=2 wrap with no halt.
        do_reset();
        chk("w2 reset", {busy2, halted2, err2, mem_rd2, cpu_load2, cpu_s2, mem_addr2}, 32'h0);
        run2 = 1'b1;
        @(negedge clk);
        run2 = 1'b0;
        busy_drop = 0;
        n = 0;
        while (fetch2_q.size() < 6 && n < 300) begin
            if (!busy2 || halted2 || err2) busy_drop = 1;
            @(negedge clk);
            n++;
        end
        chk("w2 fetch count", 32'(fetch2_q.size() >= 6), 32'h1);
        for (int i = 0; i < 6; i++) chk($sformatf("w2 addr%0d", i), fetch2_q[i], i % 4);
        chk("w2 busy held", busy_drop, 0);

        // Watchdog: cpu never leaves its wait state.
        load_prog(0);
        stuck = 1;
        do_reset();
        pulse_run();
        n = 0;
        while (!cpu_s && n < 100) begin @(negedge clk); n++; end
        t0 = cyc;
        n = 0;
        while (!err && n < 200) begin @(negedge clk); n++; end
        chk("wdt latency", cyc - t0, WDT);
        chk("wdt status", {busy, halted, err}, 3'b001);
        lc0 = fetch_q.size();
        repeat (10) @(negedge clk);
        chk("wdt no fetch", fetch_q.size(), lc0);
        chk("wdt pc frozen", mem_addr, 0);
        stuck = 0;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("err restart", {err, mem_rd, mem_addr}, {1'b0, 1'b1, 8'd0});
        wait_done("err rerun");
        chk("err rerun r2", {halted, regs[2]}, {1'b1, 16'h0010});

        // Watchdog boundary: longest execution that still completes, and one longer.
        fixed_lat = WDT - 2;
        do_reset();
        pulse_run();
        wait_done("lat max");
        chk("lat max ok", {halted, err, mem_addr}, {1'b1, 1'b0, 8'd3});
        fixed_lat = WDT - 1;
        do_reset();
        pulse_run();
        wait_done("lat over");
        chk("lat over err", {halted, err, mem_addr}, {1'b0, 1'b1, 8'd0});
        fixed_lat = 0;

        // Reset (with run held) during EXEC_HI of address 1.
        do_reset();
        pulse_run();
        n = 0;
        while (!(dut.state == EXEC_HI && mem_addr == 8'd1) && n < 300) begin @(negedge clk); n++; end
        chk("reach exec_hi", 32'(n < 300), 32'h1);
        reset = 1'b1;
        run = 1'b1;
        @(negedge clk);
        chk_idle("mid reset");
        reset = 1'b0;
        run = 1'b0;
        @(negedge clk);
        chk_idle("post reset idle");
        pulse_run();
        wait_done("restart");
        chk("restart first addr", fetch_q[0], 0);
        chk("restart fetches", fetch_q.size(), 4);
        chk("restart r2", regs[2], 16'h0010);

        // run while busy is ignored; run in HALT restarts.
        do_reset();
        pulse_run();
        n = 0;
        while (!halted && n < 300) begin
            run = busy ? 1'($urandom_range(0, 1)) : 1'b0;
            @(negedge clk);
            n++;
        end
        run = 1'b0;
        chk("busy run fetches", fetch_q.size(), 4);
        for (int i = 0; i < 4; i++) chk($sformatf("busy run addr%0d", i), fetch_q[i], i);
        chk("busy run halt", {halted, mem_addr}, {1'b1, 8'd3});
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk("halt restart", {halted, busy, mem_rd, mem_addr}, {1'b0, 1'b1, 1'b1, 8'd0});
        wait_done("halt rerun");
        chk("halt rerun loads", load_q.size(), 6);

        // cpu_w low on entry to LOAD.
        do_reset();
        pulse_run();
        chk("fetch before stall", mem_rd, 1);
        force_low = 1;
        any_load = 0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (cpu_load) any_load = 1;
        end
        chk("stall no load", {any_load, load_q.size() != 0}, 2'b00);
        force_low = 0;
        repeat (4) @(negedge clk);
        chk("stall one load", load_q.size(), 1);
        wait_done("stall");
        chk("stall r2", regs[2], 16'h0010);

        // Random programs against the scan-based reference.
        for (int r = 0; r < 6; r++) begin
            l = $urandom_range(1, 10);
            for (int i = 0; i < 256; i++) rom[i] = {3'($urandom_range(0, 6)), 13'($urandom)};
            rom[l] = {3'b111, 13'($urandom)};
            l = first_halt();
            nm = $sformatf("rnd%0d", r);
            do_reset();
            pulse_run();
            wait_done(nm);
            chk({nm, " loads"}, load_q.size(), l);
            for (int i = 0; i < l; i++) chk($sformatf("%s load%0d", nm, i), load_q[i], rom[i]);
            chk({nm, " fetches"}, fetch_q.size(), l + 1);
            for (int i = 0; i <= l; i++) chk($sformatf("%s addr%0d", nm, i), fetch_q[i], i);
            chk({nm, " end"}, {halted, err, mem_addr}, {1'b1, 1'b0, 8'(l)});
            chk({nm, " ir"}, cpu_in, rom[l]);
        end

        chk("load/s overlap", overlap, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
